apb_completer: RTL and testbench
================================

Name: apb_completer

Overview:
- APB completer (slave) endpoint for the APB fabric: the responder end of the same interface the fabric's requesters drive.
- Decodes setup/access phases, inserts a programmable number of wait states, and serves a bank of NREG 32-bit-aligned registers.
- Flags PSLVERR on illegal accesses.
- Used both as a real register target and as the reference responder behind fabric ports in verification.

Parameters:
- PADDR, 32, APB address width; max is the project-wide PADDR.
- PDATA, 32, APB data width; max is the project-wide PDATA; must be 32 in this revision.
- NREG, 16, number of registers; index 0 is the read-only ID register.
- WAIT_CYCLES, 0, wait states inserted per transfer (0..15).
- ID_VALUE, 32'hA9B0_0001, read value of register 0.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- prst  in  1  reset, synchronous, active-high.
- psel  in  1  completer select.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  PADDR  byte address.
- pwdata  in  PDATA  write data.
- pstrb  in  PDATA/8  byte strobes; used only with APB_COMPLETER_PSTRB_EN.
- pready  out  1  transfer completion, registered.
- prdata  out  PDATA  read data, registered; valid when pready=1 and pwrite=0.
- pslverr  out  1  error response, registered; valid only with pready=1.
- regs_o  out  NREG*PDATA  flat register bank contents; reg i at bits [i*PDATA +: PDATA].

Behaviour:
- Reset: prst=1 sampled at a clock edge forces the following state.
  - FSM = IDLE.
  - pready=0, prdata=0, pslverr=0.
  - Registers 1..NREG-1 = 0.
  - Any in-flight transfer is abandoned; no register update.
- FSM states:
  - IDLE: in IDLE, psel=1 and penable=0 (setup phase) → WAIT.
    - Wait counter loads WAIT_CYCLES.
    - If WAIT_CYCLES=0, go directly to RESP and assert pready next cycle.
  - WAIT: counter decrements each cycle; when it reaches 1, go to RESP and register pready=1.
  - RESP: pready=1 for exactly one cycle (the completing cycle, psel=penable=1); then → IDLE with pready=0.
- Latency: pready is high in access cycle number WAIT_CYCLES+1. WAIT_CYCLES=0 gives a zero-wait-state transfer (pready=1 in the first access cycle).
- Decode: performed at the setup edge and latched with pwrite/paddr.
  - error = (paddr[1:0]!=0) OR (paddr[PADDR-1:2] >= NREG) OR (pwrite AND index==0).
  - pslverr is registered alongside pready from the latched error.
- Write commit: on the completing edge (psel & penable & pready) with no error.
  - reg[index] <= pwdata, sampled at that edge.
  - Error writes leave all registers unchanged.
- Read: prdata is loaded when entering RESP.
  - Value = reg[index] (index 0 returns ID_VALUE).
  - On error, prdata=0.
  - prdata returns to 0 when pready drops.
- Requester-side abort: psel=0 while in WAIT or RESP → IDLE next cycle; pready=0; no write.
- Back-to-back: setup in the cycle immediately after RESP is accepted. IDLE sees the new setup in that cycle, so there is no dead cycle.
- Protocol violation: penable=1 with psel=1 while in IDLE (no setup seen) is ignored; stay IDLE, pready=0. A bench assertion flags it.
- pready never rises unless psel=1.
- Signal stability: paddr/pwrite/pwdata are required stable during a transfer; paddr and pwrite are latched at setup, so later changes to them do not affect the response.

Optional Feature:
- Macro: APB_COMPLETER_PSTRB_EN.
- Defined: byte-lane writes; byte k of reg[index] updates only if pstrb[k]=1. pstrb=0 on a write is a legal no-op (pready, no error). A read with pstrb!=0 gives pslverr=1.
- Undefined: pstrb is ignored; every write updates all bytes.

Decomposition:
- Package apb_completer_pkg:
  - state_e enum {IDLE, WAIT, RESP};
  - WAIT_W=4;
  - ID_IDX=0;
  - default PADDR/PDATA sourced from proj_param_pkg;
  - function reg_index(paddr).
- One sub-module: apb_completer_wait_ctr.
  - Loadable down-counter: load, value, done.
  - Instantiated once for wait-state generation.

Test Plan:
- WAIT_CYCLES=0; write 0xDEADBEEF to paddr 0x04, then read 0x04 → pready in first access cycle both times; pslverr=0; prdata=0xDEADBEEF; regs_o[63:32]=0xDEADBEEF.
- WAIT_CYCLES=3; read paddr 0x00 → pready high in 4th access cycle only; prdata=0xA9B0_0001.
- Error write to paddr 0x40 (NREG=16), then paddr 0x06, then paddr 0x00 → each gives pready+pslverr=1; regs_o unchanged; reads of 0x40 give prdata=0.
- WAIT_CYCLES=2; psel dropped in 2nd access cycle of a write of 0x1234 to 0x08 → FSM IDLE next cycle; reg 2 unchanged; next transfer completes normally.
- prst=1 asserted mid-WAIT after reg 3=0x55 → next cycle pready=0, reg 3=0, FSM IDLE; first post-reset read of 0x0C gives 0.
- With APB_COMPLETER_PSTRB_EN: reg 1=0x11223344, write 0xAABBCCDD with pstrb=4'b0101 → reg 1=0x11BB33DD; back-to-back transfers with no idle gap all complete.

Source files
------------

// File: rtl/apb_completer_pkg.sv
// apb_completer_pkg: FSM state type, wait-counter width, ID register index and address-to-index helper.
package apb_completer_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam int WAIT_W = 4;
    localparam int ID_IDX = 0;
    localparam int DEF_PADDR = proj_param_pkg::PADDR;
    localparam int DEF_PDATA = proj_param_pkg::PDATA;
    localparam int WORD_W = DEF_PADDR - 2;
    function automatic logic [WORD_W-1:0] reg_index(input logic [DEF_PADDR-1:0] paddr);
        return paddr[DEF_PADDR-1:2];
    endfunction
endpackage

// File: rtl/proj_param_pkg.sv
// proj_param_pkg: project-wide APB bus width limits shared by all APB blocks.
package proj_param_pkg;
    localparam int PADDR = 32;
    localparam int PDATA = 32;
endpackage

// File: rtl/apb_completer_if.sv
// apb_completer_if: APB bus bundle; master drives psel/penable/pwrite/paddr/pwdata/pstrb, slave returns pready/prdata/pslverr.
interface apb_completer_if #(
    parameter int PADDR = apb_completer_pkg::DEF_PADDR,
    parameter int PDATA = apb_completer_pkg::DEF_PDATA
);
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [PADDR-1:0]   paddr;
    logic [PDATA-1:0]   pwdata;
    logic [PDATA/8-1:0] pstrb;
    logic               pready;
    logic [PDATA-1:0]   prdata;
    logic               pslverr;
    modport master (output psel, penable, pwrite, paddr, pwdata, pstrb, input pready, prdata, pslverr);
    modport slave (input psel, penable, pwrite, paddr, pwdata, pstrb, output pready, prdata, pslverr);
endinterface

// File: rtl/apb_completer_wait_ctr.sv
// apb_completer_wait_ctr: loadable down-counter for wait states.
//   pclk/prst : clock, synchronous active-high reset
//   load      : load counter with value
//   value     : number of wait states to count
//   done      : count has reached 1 (last wait cycle)
module apb_completer_wait_ctr
    import apb_completer_pkg::*;
(
    input  logic              pclk,
    input  logic              prst,
    input  logic              load,
    input  logic [WAIT_W-1:0] value,
    output logic              done
);
    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? value : (cnt_q != '0 ? cnt_q - WAIT_W'(1) : '0);

    always_ff @(posedge pclk) begin
        if (prst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign done = cnt_q == WAIT_W'(1);
endmodule

// File: rtl/apb_completer.sv
// apb_completer: APB completer with programmable wait states, NREG registers (reg 0 = read-only ID) and PSLVERR on illegal accesses.
//   pclk/prst : clock, synchronous active-high reset
//   bus       : APB slave modport (psel, penable, pwrite, paddr, pwdata, pstrb -> pready, prdata, pslverr)
//   regs_o    : flat register bank, reg i at [i*PDATA +: PDATA]
//   APB_COMPLETER_PSTRB_EN : byte-lane writes via pstrb; reads with nonzero pstrb error. Undefined: pstrb ignored.
module apb_completer
    import apb_completer_pkg::*;
#(
    parameter int          PADDR       = DEF_PADDR,
    parameter int          PDATA       = DEF_PDATA,
    parameter int          NREG        = 16,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                  pclk,
    input  logic                  prst,
    apb_completer_if.slave        bus,
    output logic [NREG*PDATA-1:0] regs_o
);
    localparam int IDX_W = NREG > 1 ? $clog2(NREG) : 1;

    state_e              state_q, state_d;
    logic [PADDR-1:0]    addr;
    logic [WORD_W-1:0]   word;
    logic [IDX_W-1:0]    dec_idx, idx_q, idx_d, cur_idx;
    logic                dec_err, strb_err, err_q, err_d, cur_err;
    logic                write_q, write_d, cur_write;
    logic                setup, load, done, enter_resp, commit;
    logic                pready_q, pready_d, pslverr_q, pslverr_d;
    logic [PDATA-1:0]    prdata_q, prdata_d;
    logic [PDATA/8-1:0]  strb;
    logic [PDATA-1:0]    regs_q [NREG];
    logic [PDATA-1:0]    regs_d [NREG];

`ifdef APB_COMPLETER_PSTRB_EN
    assign strb     = bus.pstrb;
    assign strb_err = !bus.pwrite && bus.pstrb != '0;
`else
    logic unused_pstrb;
    assign strb         = '1;
    assign strb_err     = 1'b0;
    assign unused_pstrb = ^bus.pstrb;
`endif

    assign addr    = bus.paddr;
    assign word    = reg_index(DEF_PADDR'(addr));
    assign dec_idx = word[IDX_W-1:0];
    assign dec_err = addr[1:0] != 2'b00 || word >= WORD_W'(NREG) ||
                     (bus.pwrite && word == WORD_W'(ID_IDX)) || strb_err;

    apb_completer_wait_ctr u_wait_ctr (
        .pclk  (pclk),
        .prst  (prst),
        .load  (load),
        .value (WAIT_W'(WAIT_CYCLES)),
        .done  (done)
    );

    // Decode is taken live from the bus in IDLE (zero-wait case enters RESP at the setup edge), latched otherwise.
    always_comb begin
        setup      = bus.psel && !bus.penable;
        load       = state_q == IDLE && setup;
        cur_idx    = state_q == IDLE ? dec_idx : idx_q;
        cur_err    = state_q == IDLE ? dec_err : err_q;
        cur_write  = state_q == IDLE ? bus.pwrite : write_q;
        idx_d      = load ? dec_idx : idx_q;
        err_d      = load ? dec_err : err_q;
        write_d    = load ? bus.pwrite : write_q;
        enter_resp = (load && WAIT_CYCLES == 0) || (state_q == WAIT && bus.psel && done);
        state_d    = enter_resp ? RESP : (load || (state_q == WAIT && bus.psel)) ? WAIT : IDLE;
        pready_d   = enter_resp;
        pslverr_d  = enter_resp && cur_err;
        prdata_d   = (enter_resp && !cur_err && !cur_write) ? regs_q[cur_idx] : '0;
        commit     = state_q == RESP && bus.psel && bus.penable && pready_q && write_q && !err_q;
        regs_d     = regs_q;
        for (int k = 0; k < PDATA / 8; k++)
            if (commit && strb[k]) regs_d[idx_q][8*k +: 8] = bus.pwdata[8*k +: 8];
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q   <= IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            write_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= i == ID_IDX ? PDATA'(ID_VALUE) : '0;
        end else begin
            state_q   <= state_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            write_q   <= write_d;
            regs_q    <= regs_d;
        end
    end

    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;

    for (genvar g = 0; g < NREG; g++) begin : g_regs
        assign regs_o[g*PDATA +: PDATA] = regs_q[g];
    end
endmodule

// File: tb/tb_apb_completer.sv
// tb_apb_completer: scoreboard bench driving three completers (WAIT_CYCLES 0, 2, 3) through one shared requester.
module tb_apb_completer;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [1:0]  dsel = '0;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        rdy_a [3];
    logic        err_a [3];
    logic [31:0] rdata_a [3];
    logic [511:0] regs_a [3];
    logic [31:0] mdl [3][16];
    exp_t        sb [$];
    int          n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    apb_completer_if #(.PADDR(32), .PDATA(32)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].psel    = psel && dsel == 2'(g);
        assign bus[g].penable = penable;
        assign bus[g].pwrite  = pwrite;
        assign bus[g].paddr   = paddr;
        assign bus[g].pwdata  = pwdata;
        assign bus[g].pstrb   = pstrb;
        assign rdy_a[g]       = bus[g].pready;
        assign err_a[g]       = bus[g].pslverr;
        assign rdata_a[g]     = bus[g].prdata;
        apb_completer #(
            .PADDR(32), .PDATA(32), .NREG(16),
            .WAIT_CYCLES(g == 0 ? 0 : g == 1 ? 2 : 3),
            .ID_VALUE(ID)
        ) u_dut (
            .pclk   (clk),
            .prst   (rst),
            .bus    (bus[g].slave),
            .regs_o (regs_a[g])
        );
    end

    assign pready  = rdy_a[dsel];
    assign pslverr = err_a[dsel];
    assign prdata  = rdata_a[dsel];

    function automatic int wc(input int d);
        return d == 0 ? 0 : d == 1 ? 2 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++) mdl[d][i] = i == 0 ? ID : 32'h0;
    endtask

    task automatic check_regs(input int d);
        for (int i = 0; i < 16; i++)
            chk($sformatf("d%0d reg%0d", d, i), regs_a[d][i*32 +: 32], mdl[d][i]);
    endtask

    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] data, input logic [3:0] strb);
        exp_t        e;
        int          n;
        logic [29:0] wi;
        logic [3:0]  s;
        logic [31:0] m;
        wi = a[31:2];
        s  = strb;
        e.err = a[1:0] != 2'b00 || wi >= 30'd16 || (w && wi == 30'd0);
`ifdef APB_COMPLETER_PSTRB_EN
        e.err = e.err || (!w && strb != 4'h0);
`else
        s = 4'hF;
`endif
        e.rdata = (!w && !e.err) ? mdl[d][wi[3:0]] : 32'h0;
        e.lat   = wc(d) + 1;
        sb.push_back(e);
        @(negedge clk);
        dsel = 2'(d); psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = data; pstrb = strb;
        @(negedge clk);
        penable = 1'b1;
        n = 1;
        while (!pready && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        chk($sformatf("d%0d lat %h", d, a), 32'(n), 32'(e.lat));
        chk($sformatf("d%0d pslverr %h", d, a), 32'(pslverr), 32'(e.err));
        if (!w) chk($sformatf("d%0d prdata %h", d, a), prdata, e.rdata);
        if (w && !e.err) begin
            m = mdl[d][wi[3:0]];
            for (int k = 0; k < 4; k++) if (s[k]) m[8*k +: 8] = data[8*k +: 8];
            mdl[d][wi[3:0]] = m;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        chk("idle pready", 32'(pready), 32'h0);
        chk("idle prdata", prdata, 32'h0);
        chk("idle pslverr", 32'(pslverr), 32'h0);
        psel = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_model();
        repeat (3) @(negedge clk);
        chk("reset pready", 32'(pready), 32'h0);
        chk("reset prdata", prdata, 32'h0);
        chk("reset pslverr", 32'(pslverr), 32'h0);
        for (int d = 0; d < 3; d++) check_regs(d);
        rst = 1'b0;

        xfer(0, 1, 32'h04, 32'hDEADBEEF, 4'hF);
        xfer(0, 0, 32'h04, 32'h0, 4'h0);
        idle();
        chk("reg1 deadbeef", regs_a[0][63:32], 32'hDEADBEEF);

        xfer(0, 1, 32'h40, 32'h11111111, 4'hF);
        xfer(0, 1, 32'h06, 32'h22222222, 4'hF);
        xfer(0, 1, 32'h00, 32'h33333333, 4'hF);
        xfer(0, 0, 32'h40, 32'h0, 4'h0);
        xfer(0, 1, 32'h3C, 32'h0F0F0F0F, 4'hF);
        xfer(0, 0, 32'h3C, 32'h0, 4'h0);
        idle();
        check_regs(0);

        @(negedge clk);
        dsel = 2'd0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h04;
        repeat (2) begin
            @(negedge clk);
            chk("violation pready", 32'(pready), 32'h0);
        end
        psel = 1'b0; penable = 1'b0;
        xfer(0, 0, 32'h04, 32'h0, 4'h0);
        idle();

        xfer(2, 0, 32'h00, 32'h0, 4'h0);
        xfer(2, 1, 32'h14, 32'hCAFE0005, 4'hF);
        xfer(2, 0, 32'h14, 32'h0, 4'h0);
        idle();

        xfer(1, 1, 32'h08, 32'h00000077, 4'hF);
        idle();
        @(negedge clk);
        dsel = 2'd1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h1234; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        chk("abort acc1 pready", 32'(pready), 32'h0);
        @(negedge clk);
        chk("abort acc2 pready", 32'(pready), 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort idle pready", 32'(pready), 32'h0);
        @(negedge clk);
        chk("abort idle2 pready", 32'(pready), 32'h0);
        check_regs(1);
        xfer(1, 0, 32'h08, 32'h0, 4'h0);
        idle();

        xfer(0, 1, 32'h04, 32'h11223344, 4'hF);
        xfer(0, 1, 32'h04, 32'hAABBCCDD, 4'b0101);
        xfer(0, 0, 32'h04, 32'h0, 4'h0);
        xfer(0, 1, 32'h08, 32'h99999999, 4'h0);
        xfer(0, 0, 32'h04, 32'h0, 4'h1);
        idle();
`ifdef APB_COMPLETER_PSTRB_EN
        chk("strb reg1", regs_a[0][63:32], 32'h11BB33DD);
`endif
        check_regs(0);

        xfer(2, 1, 32'h0C, 32'h00000055, 4'hF);
        idle();
        chk("reg3 55", regs_a[2][127:96], 32'h55);
        @(negedge clk);
        dsel = 2'd2; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0C; pstrb = 4'h0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset pready", 32'(pready), 32'h0);
        chk("midreset reg3", regs_a[2][127:96], 32'h0);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        reset_model();
        xfer(2, 0, 32'h0C, 32'h0, 4'h0);
        idle();
        for (int d = 0; d < 3; d++) check_regs(d);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
